uart_rx_core: RTL

Receive-side UART deserialiser that sits directly downstream of one_shot. one_shot converts the falling edge of the start bit on the synchronised rx line into a single-cycle start pulse. This block uses that pulse as its frame trigger, times the bit centres, shifts in the data LSB-first, checks the stop bit, and delivers a byte with a one-cycle valid strobe. Its output feeds the RX holding register / FIFO.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_core_bit_timer.sv | 38 +++
 rtl/uart_rx_core.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and default constants shared by the UART receive path,
// the TX side and the one_shot benches.
//   rx_state_t        receive FSM state encoding (IDLE, START, DATA, STOP)
//   CLKS_PER_BIT_DEF  default clk cycles per UART bit
//   DATA_BITS_DEF     default data bits per frame
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_rx_core_bit_timer.sv
// rx_bit_timer: clock counter that times UART bit periods for the receiver.
//   clk        system clock, rising-edge
//   rst        asynchronous active-high reset
//   clear      synchronous clear of the counter (dominates enable)
//   enable     advance the counter by one this cycle
//   half_tick  count == CLKS_PER_BIT/2-1 (mid-start-bit sample point)
//   full_tick  count == CLKS_PER_BIT-1   (one full bit period elapsed)
module rx_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic full_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign half_tick = (count == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign full_tick = (count == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receive deserialiser triggered by the one_shot start pulse.
//   clk          system clock, rising-edge
//   RST          asynchronous active-high reset
//   start_pulse  one-cycle pulse marking the start-bit falling edge
//   rx           synchronised serial line, idle high
//   data_out     last correctly framed byte, LSB = first bit received
//   data_valid   one-cycle strobe, data_out is new this cycle
//   frame_err    one-cycle strobe, stop bit sampled low and byte discarded
//   busy         high whenever the FSM is not IDLE
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 start_pulse,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  rx_state_t            state;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 timer_clear;
  logic                 timer_enable;
  logic                 half_tick;
  logic                 full_tick;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (RST),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  // Holding the counter cleared throughout IDLE means it is already zero on
  // the cycle after start_pulse is captured, so START counts from 0.
  always_comb begin
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    case (state)
      IDLE:  timer_clear = 1'b1;
      START: begin
        timer_enable = 1'b1;
        timer_clear  = half_tick;
      end
      DATA, STOP: begin
        timer_enable = 1'b1;
        timer_clear  = full_tick;
      end
      default: timer_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_pulse) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (half_tick) begin
            if (!rx) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // line went back high before mid-bit: treat as a glitch
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (full_tick) begin
            shift_reg <= {rx, shift_reg[DATA_BITS-1:1]};
            bit_idx   <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (full_tick) begin
            if (rx) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
